paridade_serial_chk: RTL and testbench

//  Sequential, parametrised successor to the combinational parity checker.

---
 rtl/paridade_serial_chk_pkg.sv | 17 +
 rtl/paridade_err_counter.sv | 29 ++
 rtl/paridade_serial_chk.sv | 119 +++++++++++
 tb/tb_paridade_serial_chk.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/paridade_serial_chk_pkg.sv
// Shared constants for the serial parity checker: FSM encodings, parity modes
// and the per-frame parity check.
package paridade_serial_chk_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // acc is the XOR of all data bits; the odd flag inverts the expected parity.
  function automatic logic parity_err(input logic acc, input logic par_bit, input logic odd);
    return acc ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/paridade_err_counter.sv
// Saturating event counter; clear takes priority over increment.
module paridade_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  // Count increments, holding at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_q <= {CNT_W{1'b0}};
    end else if (i_inc && !(&r_q)) begin
      r_q <= r_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/paridade_serial_chk.sv
// Deserialises WIDTH-bit frames followed by a parity bit, checks even/odd
// parity and reports each completed word with a one-cycle valid pulse.
module paridade_serial_chk
  import paridade_serial_chk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_odd_mode,
  input  logic             i_bit_valid,
  input  logic             i_bit_in,
  input  logic             i_clr_count,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  output logic             o_par_err,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int BCW = $clog2(WIDTH + 1);

  logic [1:0]       r_state;
  logic [BCW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_acc;
  logic             r_odd;
  logic             r_valid;
  logic             r_err;
  logic [WIDTH-1:0] w_shift_nxt;

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shift_nxt = i_bit_in;
    end else if (LSB_FIRST != 0) begin : g_lsb
      // After WIDTH shifts the first bit has travelled down to bit 0.
      assign w_shift_nxt = {i_bit_in, r_shift[WIDTH-1:1]};
    end else begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], i_bit_in};
    end
  endgenerate

  // Frame FSM; start restarts from any state and beats bit_valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {BCW{1'b0}};
      r_shift <= {WIDTH{1'b0}};
      r_word  <= {WIDTH{1'b0}};
      r_acc   <= 1'b0;
      r_odd   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (i_start) begin
        r_state <= ST_DATA;
        r_cnt   <= {BCW{1'b0}};
        r_shift <= {WIDTH{1'b0}};
        r_acc   <= 1'b0;
        r_odd   <= i_odd_mode;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_DATA: begin
            if (i_bit_valid) begin
              r_shift <= w_shift_nxt;
              r_acc   <= r_acc ^ i_bit_in;
              r_cnt   <= r_cnt + BCW'(1);
              if (r_cnt == BCW'(WIDTH - 1)) begin
                r_state <= ST_PARITY;
              end else begin
                r_state <= ST_DATA;
              end
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_PARITY: begin
            if (i_bit_valid) begin
              r_state <= ST_IDLE;
              r_word  <= r_shift;
              r_valid <= 1'b1;
              r_err   <= parity_err(r_acc, i_bit_in, r_odd);
            end else begin
              r_state <= ST_PARITY;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  paridade_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_counter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (r_err),
    .i_clr (i_clr_count),
    .o_q   (o_err_count)
  );

  assign o_word_out   = r_word;
  assign o_word_valid = r_valid;
  assign o_par_err    = r_err;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_paridade_serial_chk.sv
// Directed bench: one shared serial stream drives an LSB-first, an MSB-first
// and a 2-bit-counter instance of the checker.
module tb_paridade_serial_chk;
  import paridade_serial_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic odd_mode = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic clr_count = 1'b0;

  logic [7:0] a_word, m_word, s_word;
  logic       a_valid, m_valid, s_valid;
  logic       a_err, m_err, s_err;
  logic       a_busy, m_busy, s_busy;
  logic [7:0] a_cnt, m_cnt;
  logic [1:0] s_cnt;

  int nvec = 0;
  int nerr = 0;
  int npulse = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (a_valid) npulse <= npulse + 1;

  paridade_serial_chk #(.WIDTH(8), .CNT_W(8), .LSB_FIRST(1)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_odd_mode(odd_mode),
    .i_bit_valid(bit_valid), .i_bit_in(bit_in), .i_clr_count(clr_count),
    .o_word_out(a_word), .o_word_valid(a_valid), .o_par_err(a_err),
    .o_busy(a_busy), .o_err_count(a_cnt));

  paridade_serial_chk #(.WIDTH(8), .CNT_W(8), .LSB_FIRST(0)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_odd_mode(odd_mode),
    .i_bit_valid(bit_valid), .i_bit_in(bit_in), .i_clr_count(clr_count),
    .o_word_out(m_word), .o_word_valid(m_valid), .o_par_err(m_err),
    .o_busy(m_busy), .o_err_count(m_cnt));

  paridade_serial_chk #(.WIDTH(8), .CNT_W(2), .LSB_FIRST(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_odd_mode(odd_mode),
    .i_bit_valid(bit_valid), .i_bit_in(bit_in), .i_clr_count(clr_count),
    .o_word_out(s_word), .o_word_valid(s_valid), .o_par_err(s_err),
    .o_busy(s_busy), .o_err_count(s_cnt));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic odd);
    start = 1'b1;
    odd_mode = odd;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in = b;
    tick();
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  // Data bits go out d[0] first; gap idle cycles follow every data bit.
  task automatic send_data(input logic [7:0] d, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      repeat (gap) tick();
    end
  endtask

  initial begin
    // 1: reset, then reset again in the middle of a frame
    tick(); tick();
    rst = 1'b0;
    start_frame(PAR_EVEN);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("busy_before_rst", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_word", {24'd0, a_word}, 32'h0);
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_err", {31'd0, a_err}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_cnt", {24'd0, a_cnt}, 32'd0);
    check("rst_busy_sat", {31'd0, s_busy}, 32'd0);

    // 2: even frame A5, parity 0
    start_frame(PAR_EVEN);
    send_data(8'hA5, 0);
    check("a5_busy_at_parity", {31'd0, a_busy}, 32'd1);
    check("a5_no_early_valid", {31'd0, a_valid}, 32'd0);
    send_bit(1'b0);
    check("a5_valid", {31'd0, a_valid}, 32'd1);
    check("a5_word", {24'd0, a_word}, 32'hA5);
    check("a5_err", {31'd0, a_err}, 32'd0);
    check("a5_word_msb", {24'd0, m_word}, 32'hA5);
    tick();
    check("a5_pulse_end", {31'd0, a_valid}, 32'd0);
    check("a5_word_held", {24'd0, a_word}, 32'hA5);
    check("a5_idle", {31'd0, a_busy}, 32'd0);

    // 3: odd FF with wrong then right parity
    start_frame(PAR_ODD);
    send_data(8'hFF, 0);
    send_bit(1'b0);
    check("ff_bad_valid", {31'd0, a_valid}, 32'd1);
    check("ff_bad_err", {31'd0, a_err}, 32'd1);
    tick();
    check("ff_bad_err_clr", {31'd0, a_err}, 32'd0);
    check("ff_bad_cnt", {24'd0, a_cnt}, 32'd1);
    start_frame(PAR_ODD);
    send_data(8'hFF, 0);
    send_bit(1'b1);
    check("ff_good_err", {31'd0, a_err}, 32'd0);
    check("ff_good_word", {24'd0, a_word}, 32'hFF);
    tick();
    check("ff_good_cnt", {24'd0, a_cnt}, 32'd1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst2_word", {24'd0, a_word}, 32'h0);
    check("rst2_cnt", {24'd0, a_cnt}, 32'd0);

    // 4: stalls between bits, then an aborted frame followed by 3C
    start_frame(PAR_EVEN);
    send_data(8'hA5, 3);
    send_bit(1'b0);
    check("gap_valid", {31'd0, a_valid}, 32'd1);
    check("gap_word", {24'd0, a_word}, 32'hA5);
    check("gap_err", {31'd0, a_err}, 32'd0);
    tick();
    npulse = 0;
    start_frame(PAR_EVEN);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    start_frame(PAR_EVEN);
    send_data(8'h3C, 0);
    send_bit(1'b0);
    check("abort_word", {24'd0, a_word}, 32'h3C);
    check("abort_err", {31'd0, a_err}, 32'd0);
    tick(); tick();
    check("abort_pulses", npulse, 32'd1);

    // 5: saturation of a 2-bit counter and clear beating increment
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    for (int k = 0; k < 5; k++) begin
      start_frame(PAR_ODD);
      send_data(8'hFF, 0);
      send_bit(1'b0);
      tick();
    end
    check("sat_cnt2", {30'd0, s_cnt}, 32'd3);
    check("sat_cnt8", {24'd0, a_cnt}, 32'd5);
    start_frame(PAR_ODD);
    send_data(8'hFF, 0);
    send_bit(1'b0);
    check("clr_par_err", {31'd0, s_err}, 32'd1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_wins_sat", {30'd0, s_cnt}, 32'd0);
    check("clr_wins_main", {24'd0, a_cnt}, 32'd0);

    // 6: reset mid-frame, then 01 and a back-to-back C4 frame
    npulse = 0;
    start_frame(PAR_EVEN);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst3_busy", {31'd0, a_busy}, 32'd0);
    check("rst3_valid", {31'd0, a_valid}, 32'd0);
    tick(); tick();
    check("rst3_no_pulse", npulse, 32'd0);
    start_frame(PAR_EVEN);
    send_data(8'h01, 0);
    send_bit(1'b1);
    check("w01_valid", {31'd0, a_valid}, 32'd1);
    check("w01_word", {24'd0, a_word}, 32'h01);
    check("w01_err", {31'd0, a_err}, 32'd0);
    check("w01_word_msb", {24'd0, m_word}, 32'h80);
    start_frame(PAR_EVEN);
    check("b2b_busy", {31'd0, a_busy}, 32'd1);
    send_data(8'hC4, 0);
    send_bit(1'b1);
    check("c4_valid", {31'd0, a_valid}, 32'd1);
    check("c4_word", {24'd0, a_word}, 32'hC4);
    check("c4_word_msb", {24'd0, m_word}, 32'h23);
    check("c4_err", {31'd0, a_err}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
